// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, oversampling constants and helpers
package uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 7;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF rx synchronizer plus one-clock delayed copy for edge detection
module uart_rx_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic rx_i,
    output logic rx_s_o,
    output logic rx_prev_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // All stages reset high so a reset never fabricates a start edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o    = sync_q;
    assign rx_prev_o = prev_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampling UART receiver with framing-error flag
// Optional UART_RX_MAJORITY_EN: majority-of-3 bit sampling for glitch rejection.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             rx,
    input  logic             sample_tick,
    output logic [DBITS-1:0] data_out,
    output logic             rx_done,
    output logic             frame_err,
    output logic [1:0]       state_out
);

    localparam int S_MAX = (SB_TICK - 1 > OVERSAMPLE - 1) ? SB_TICK - 1 : OVERSAMPLE - 1;
    localparam int S_W   = $clog2(S_MAX + 1);
    localparam int N_W   = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(START_MID);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [S_W-1:0] S_ONE  = S_W'(1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBITS - 1);
    localparam logic [N_W-1:0] N_ONE  = N_W'(1);

    uart_state_e      state_q, state_d;
    logic [S_W-1:0]   s_cnt_q, s_cnt_d;
    logic [N_W-1:0]   n_cnt_q, n_cnt_d;
    logic [DBITS-1:0] b_q, b_d;
    logic [DBITS-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;

    logic rx_s;
    logic rx_prev;
    logic bit_sample;

    uart_rx_sync u_sync (
        .clk_i     (clk_100MHz),
        .reset_i   (reset),
        .rx_i      (rx),
        .rx_s_o    (rx_s),
        .rx_prev_o (rx_prev)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (sample_tick && (state_q != UART_IDLE)) begin
            hist_d = {hist_q[1:0], rx_s};
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            hist_q <= '1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign bit_sample = majority3(hist_q[1], hist_q[0], rx_s);
`else
    assign bit_sample = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        data_d  = data_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            // Start detection is edge-based and not gated by sample_tick.
            UART_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_d = UART_START;
                    s_cnt_d = '0;
                end
            end
            UART_START: begin
                if (sample_tick) begin
                    if (s_cnt_q == S_MID) begin
                        if (!bit_sample) begin
                            state_d = UART_DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = UART_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + S_ONE;
                    end
                end
            end
            UART_DATA: begin
                if (sample_tick) begin
                    if (s_cnt_q == S_BIT) begin
                        s_cnt_d = '0;
                        b_d     = {bit_sample, b_q[DBITS-1:1]};
                        if (n_cnt_q == N_LAST) begin
                            state_d = UART_STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + N_ONE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + S_ONE;
                    end
                end
            end
            UART_STOP: begin
                if (sample_tick) begin
                    if (s_cnt_q == S_STOP) begin
                        data_d  = b_q;
                        ferr_d  = ~bit_sample;
                        done_d  = 1'b1;
                        state_d = UART_IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + S_ONE;
                    end
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q <= UART_IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out  = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

    logic       clk_100MHz;
    logic       reset;
    logic       rx;
    logic       sample_tick;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic [1:0] state_out;

    int n_cmp;
    int n_fail;
    int done_cnt;
    logic [7:0] cap_data;
    logic       cap_ferr;
    int tdiv;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         glitch;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[4];

    uart_receiver #(.DBITS(8), .SB_TICK(16)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .rx          (rx),
        .sample_tick (sample_tick),
        .data_out    (data_out),
        .rx_done     (rx_done),
        .frame_err   (frame_err),
        .state_out   (state_out)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    // Tick every 4th clock, updated just after the edge so negedge readers see it stable.
    initial begin
        sample_tick = 1'b0;
        tdiv = 0;
        forever begin
            @(posedge clk_100MHz);
            #1;
            tdiv = (tdiv + 1) % 4;
            sample_tick = (tdiv == 0);
        end
    end

    initial begin
        done_cnt = 0;
        cap_data = 8'h00;
        cap_ferr = 1'b0;
        forever begin
            @(negedge clk_100MHz);
            if (rx_done) begin
                done_cnt = done_cnt + 1;
                cap_data = data_out;
                cap_ferr = frame_err;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives nbits bit-times of a frame (start, 8 data LSB first, stop), 64 clocks each,
    // starting on a tick-aligned clock. glitch>=0 puts a 4-clock high pulse over the
    // decision tick of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch, input int nbits);
        do @(negedge clk_100MHz); while (!sample_tick);
        for (int i = 0; i < nbits * 64; i++) begin
            int   k;
            logic v;
            if (i > 0) @(negedge clk_100MHz);
            k = i / 64;
            if (k == 0) v = 1'b0;
            else if (k <= 8) v = d[k-1];
            else v = stop;
            if (glitch >= 0 && i >= 92 + 64 * glitch && i <= 95 + 64 * glitch) v = 1'b1;
            rx = v;
        end
    endtask

    initial begin
        int c0;
        logic [7:0] d0;
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        rx     = 1'b1;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, glitch: -1, exp_data: 8'hA5, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, glitch: -1, exp_data: 8'h00, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, glitch: -1, exp_data: 8'hFF, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'h00, stop: 1'b1, glitch: 2,  exp_data: GLITCH_EXP, exp_ferr: 1'b0};

        repeat (5) @(negedge clk_100MHz);
        check("reset_data", 32'(data_out), 32'h00);
        check("reset_done", 32'(rx_done), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        check("reset_state", 32'(state_out), 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk_100MHz);

        // Frames sent back-to-back with no idle gap between them.
        for (int v = 0; v < 4; v++) begin
            c0 = done_cnt;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].glitch, 10);
            check($sformatf("vec%0d_done_count", v), 32'(done_cnt - c0), 32'd1);
            check($sformatf("vec%0d_data", v), 32'(cap_data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_ferr", v), 32'(cap_ferr), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_state", v), 32'(state_out), 32'h0);
        end

        // False start: low for 4 ticks only.
        repeat (64) @(negedge clk_100MHz);
        c0 = done_cnt;
        d0 = data_out;
        do @(negedge clk_100MHz); while (!sample_tick);
        rx = 1'b0;
        for (int i = 1; i < 112; i++) begin
            @(negedge clk_100MHz);
            if (i == 16) rx = 1'b1;
            if (i == 4) check("false_start_state_start", 32'(state_out), 32'h1);
            if (i == 48) check("false_start_state_idle", 32'(state_out), 32'h0);
        end
        check("false_start_no_done", 32'(done_cnt - c0), 32'd0);
        check("false_start_data_kept", 32'(data_out), 32'(d0));

        // Low stop bit, line held low for 100 ticks afterwards.
        c0 = done_cnt;
        send_frame(8'h3C, 1'b0, -1, 10);
        repeat (400) @(negedge clk_100MHz);
        check("ferr_done_count", 32'(done_cnt - c0), 32'd1);
        check("ferr_data", 32'(cap_data), 32'h3C);
        check("ferr_flag", 32'(cap_ferr), 32'h1);
        check("ferr_flag_held", 32'(frame_err), 32'h1);
        rx = 1'b1;
        repeat (64) @(negedge clk_100MHz);
        send_frame(8'h81, 1'b1, -1, 10);
        check("after_ferr_done_count", 32'(done_cnt - c0), 32'd2);
        check("after_ferr_data", 32'(cap_data), 32'h81);
        check("after_ferr_flag", 32'(cap_ferr), 32'h0);

        // Reset in the middle of a frame, then a clean frame.
        repeat (64) @(negedge clk_100MHz);
        c0 = done_cnt;
        send_frame(8'h5A, 1'b1, -1, 4);
        @(negedge clk_100MHz);
        rx = 1'b1;
        reset = 1'b1;
        @(negedge clk_100MHz);
        reset = 1'b0;
        check("midreset_data", 32'(data_out), 32'h00);
        check("midreset_ferr", 32'(frame_err), 32'h0);
        check("midreset_done", 32'(rx_done), 32'h0);
        check("midreset_state", 32'(state_out), 32'h0);
        repeat (700) @(negedge clk_100MHz);
        check("midreset_no_done", 32'(done_cnt - c0), 32'd0);
        send_frame(8'h5A, 1'b1, -1, 10);
        check("post_reset_done_count", 32'(done_cnt - c0), 32'd1);
        check("post_reset_data", 32'(data_out), 32'h5A);
        check("post_reset_ferr", 32'(frame_err), 32'h0);

        repeat (20) @(negedge clk_100MHz);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
